cve2_rf_wr_arbiter: RTL and testbench

Owns the single register-file write port and shares it between two requesters: ID/EX results and LSU load data. LSU load data has absolute priority because it cannot be stalled. ID/EX writes that lose arbitration are held in a small in-order queue, which also exposes a busy-register scoreboard and a forwarding lookup to ID. The block sits between the ID/EX stage, the LSU and the register file, replacing the direct write-data mux.

---
 rtl/cve2_pkg.sv | 17 +
 rtl/cve2_rf_wr_queue.sv | 58 +++++
 rtl/cve2_rf_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_cve2_rf_wr_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cve2_pkg.sv
// Shared types for the register-file write path.
// The write arbiter and its holding queue pass requests around as rf_wr_req_t.
package cve2_pkg;

    localparam int unsigned RegAddrW = 5;
    localparam int unsigned XLen     = 32;

    typedef struct packed {
        logic [RegAddrW-1:0] waddr;
        logic [XLen-1:0]     wdata;
    } rf_wr_req_t;

    function automatic logic [XLen-1:0] reg_onehot(input logic [RegAddrW-1:0] i_addr);
        return XLen'(1) << i_addr;
    endfunction

endpackage

// File: rtl/cve2_rf_wr_queue.sv
// In-order circular buffer holding deferred ID/EX register-file writes.
// Entries are presented oldest first, with a matching valid mask.
module cve2_rf_wr_queue
    import cve2_pkg::*;
#(
    parameter int unsigned QueueDepth = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_push,
    input  rf_wr_req_t            i_push_req,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output rf_wr_req_t            o_entries [QueueDepth],
    output logic [QueueDepth-1:0] o_valid
);

    localparam int unsigned PtrW = $clog2(QueueDepth);
    localparam int unsigned CntW = $clog2(QueueDepth + 1);

    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;
    rf_wr_req_t      r_mem [QueueDepth];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (i_push) r_mem[r_wptr] <= i_push_req;
    end

    always_comb begin
        for (int i = 0; i < int'(QueueDepth); i++) begin
            o_entries[i] = r_mem[r_rptr + PtrW'(i)];
            o_valid[i]   = (CntW'(i) < r_count);
        end
    end

    assign o_full  = (r_count == CntW'(QueueDepth));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/cve2_rf_wr_arbiter.sv
// Shares the single register-file write port between LSU load data and ID/EX
// results; losing ID/EX writes wait in an in-order queue visible to ID.
module cve2_rf_wr_arbiter
    import cve2_pkg::*;
#(
    parameter int unsigned QueueDepth = 2,
    parameter int unsigned CntWidth   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ex_req_i,
    input  logic [4:0]          ex_waddr_i,
    input  logic [31:0]         ex_wdata_i,
    output logic                ex_gnt_o,
    input  logic                lsu_req_i,
    input  logic [4:0]          lsu_waddr_i,
    input  logic [31:0]         lsu_wdata_i,
    input  logic                lsu_err_i,
    output logic                rf_we_o,
    output logic [4:0]          rf_waddr_o,
    output logic [31:0]         rf_wdata_o,
    output logic [31:0]         busy_regs_o,
    input  logic [4:0]          fwd_raddr_i,
    output logic                fwd_hit_o,
    output logic [31:0]         fwd_data_o,
    output logic                idle_o,
    input  logic                perf_clr_i,
    output logic [CntWidth-1:0] collision_cnt_o
);

    logic                  w_lsu_w;
    logic                  w_ex_eff;
    logic                  w_q_full;
    logic                  w_q_empty;
    logic                  w_deq;
    logic                  w_direct;
    logic                  w_enq;
    rf_wr_req_t            w_entries [QueueDepth];
    logic [QueueDepth-1:0] w_valid;
    logic [CntWidth-1:0]   r_collision_cnt;

    assign w_lsu_w  = lsu_req_i & ~lsu_err_i & (lsu_waddr_i != '0);
    assign w_ex_eff = ex_req_i & (ex_waddr_i != '0);

    // Loads cannot stall, so they always win; the queue head drains before new ID/EX work.
    assign w_deq    = rst_ni & ~w_q_empty & ~w_lsu_w;
    assign ex_gnt_o = rst_ni & (~w_q_full | w_deq);
    assign w_direct = w_ex_eff & ex_gnt_o & w_q_empty & ~w_lsu_w;
    assign w_enq    = w_ex_eff & ex_gnt_o & ~w_direct;

    cve2_rf_wr_queue #(
        .QueueDepth (QueueDepth)
    ) u_queue (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_push     (w_enq),
        .i_push_req ('{waddr: ex_waddr_i, wdata: ex_wdata_i}),
        .i_pop      (w_deq),
        .o_full     (w_q_full),
        .o_empty    (w_q_empty),
        .o_entries  (w_entries),
        .o_valid    (w_valid)
    );

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (rst_ni) begin
            if (w_lsu_w) begin
                rf_we_o    = 1'b1;
                rf_waddr_o = lsu_waddr_i;
                rf_wdata_o = lsu_wdata_i;
            end else if (!w_q_empty) begin
                rf_we_o    = 1'b1;
                rf_waddr_o = w_entries[0].waddr;
                rf_wdata_o = w_entries[0].wdata;
            end else if (w_direct) begin
                rf_we_o    = 1'b1;
                rf_waddr_o = ex_waddr_i;
                rf_wdata_o = ex_wdata_i;
            end
        end
    end

    // Entries are scanned oldest to youngest so the youngest match wins forwarding.
    always_comb begin
        busy_regs_o = '0;
        fwd_hit_o   = 1'b0;
        fwd_data_o  = '0;
        for (int i = 0; i < int'(QueueDepth); i++) begin
            if (w_valid[i]) begin
                busy_regs_o = busy_regs_o | reg_onehot(w_entries[i].waddr);
                if ((fwd_raddr_i != '0) && (w_entries[i].waddr == fwd_raddr_i)) begin
                    fwd_hit_o  = 1'b1;
                    fwd_data_o = w_entries[i].wdata;
                end
            end
        end
        busy_regs_o[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_collision_cnt <= '0;
        end else if (perf_clr_i) begin
            r_collision_cnt <= '0;
        end else if (w_lsu_w & (w_ex_eff | ~w_q_empty) & ~(&r_collision_cnt)) begin
            r_collision_cnt <= r_collision_cnt + 1'b1;
        end
    end

    assign collision_cnt_o = r_collision_cnt;
    assign idle_o          = w_q_empty;

    // ID stalls on busy registers, so a load never targets a queued destination.
    a_no_waw : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_lsu_w && busy_regs_o[lsu_waddr_i]));
    a_one_src : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0({w_lsu_w, w_deq, w_direct}));

endmodule

// File: tb/tb_cve2_rf_wr_arbiter.sv
// Bench for cve2_rf_wr_arbiter: directed cycle table, hand-written corner
// sequences, then randomized traffic against a queue-level reference model.
module tb_cve2_rf_wr_arbiter;

    localparam int QD     = 2;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_req;
    logic [4:0]    ex_waddr;
    logic [31:0]   ex_wdata;
    logic          ex_gnt;
    logic          lsu_req;
    logic [4:0]    lsu_waddr;
    logic [31:0]   lsu_wdata;
    logic          lsu_err;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [31:0]   busy_regs;
    logic [4:0]    fwd_raddr;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic          idle;
    logic          perf_clr;
    logic [CW-1:0] coll_cnt;

    cve2_rf_wr_arbiter #(.QueueDepth(QD), .CntWidth(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ex_req_i(ex_req), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_gnt_o(ex_gnt),
        .lsu_req_i(lsu_req), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_err_i(lsu_err),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .busy_regs_o(busy_regs), .fwd_raddr_i(fwd_raddr), .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
        .idle_o(idle), .perf_clr_i(perf_clr), .collision_cnt_o(coll_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst; logic exr; logic [4:0] exa; logic [31:0] exd;
        logic        lr;  logic [4:0] la; logic [31:0] ld; logic le;
        logic [4:0]  fa;  logic clr;
        logic        gnt; logic we; logic [4:0] wa; logic [31:0] wd;
        logic [31:0] busy; logic hit; logic [31:0] fd; logic idle; int cnt;
    } vec_t;

    typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;

    vec_t tbl[$];
    ent_t mq[$];
    int   mcnt;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic rst, logic exr, logic [4:0] exa, logic [31:0] exd,
                                logic lr, logic [4:0] la, logic [31:0] ld, logic le,
                                logic [4:0] fa, logic clr,
                                logic gnt, logic we, logic [4:0] wa, logic [31:0] wd,
                                logic [31:0] busy, logic hit, logic [31:0] fd, logic idl, int cnt);
        vec_t v;
        v.rst = rst; v.exr = exr; v.exa = exa; v.exd = exd;
        v.lr = lr; v.la = la; v.ld = ld; v.le = le; v.fa = fa; v.clr = clr;
        v.gnt = gnt; v.we = we; v.wa = wa; v.wd = wd;
        v.busy = busy; v.hit = hit; v.fd = fd; v.idle = idl; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic exr, input logic [4:0] exa, input logic [31:0] exd,
                         input logic lr, input logic [4:0] la, input logic [31:0] ld, input logic le,
                         input logic [4:0] fa, input logic clr);
        rst_n = rst; ex_req = exr; ex_waddr = exa; ex_wdata = exd;
        lsu_req = lr; lsu_waddr = la; lsu_wdata = ld; lsu_err = le;
        fwd_raddr = fa; perf_clr = clr;
    endtask

    task automatic check_outs(input string tag, input logic gnt, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic [31:0] busy, input logic hit,
                              input logic [31:0] fd, input logic idl, input int cnt);
        chk({tag, " gnt"},  64'(ex_gnt),    64'(gnt));
        chk({tag, " we"},   64'(rf_we),     64'(we));
        chk({tag, " port"}, {27'd0, rf_waddr, rf_wdata}, {27'd0, wa, wd});
        chk({tag, " busy"}, 64'(busy_regs), 64'(busy));
        chk({tag, " fwd"},  {31'd0, fwd_hit, fwd_data}, {31'd0, hit, fd});
        chk({tag, " idle"}, 64'(idle),      64'(idl));
        chk({tag, " cnt"},  64'(coll_cnt),  64'(cnt));
    endtask

    // Reference model: expected outputs for the current cycle, then state advance.
    task automatic model_step(input logic rst, input logic exr, input logic [4:0] exa, input logic [31:0] exd,
                              input logic lr, input logic [4:0] la, input logic [31:0] ld, input logic le,
                              input logic [4:0] fa, input logic clr, input string tag);
        int          n   = mq.size();
        logic        lw  = lr && !le && (la != 0);
        logic        ee  = exr && (exa != 0);
        logic        gnt = 1'b0;
        logic        we  = 1'b0;
        logic [4:0]  wa  = '0;
        logic [31:0] wd  = '0;
        logic [31:0] busy = '0;
        logic        hit = 1'b0;
        logic [31:0] fd  = '0;
        ent_t        e;
        if (rst) begin
            gnt = (n < QD) || (n > 0 && !lw);
            if (lw) begin we = 1; wa = la; wd = ld; end
            else if (n > 0) begin we = 1; wa = mq[0].a; wd = mq[0].d; end
            else if (ee) begin we = 1; wa = exa; wd = exd; end
        end
        foreach (mq[k]) begin
            busy[mq[k].a] = 1'b1;
            if (fa != 0 && mq[k].a == fa) begin hit = 1; fd = mq[k].d; end
        end
        busy[0] = 1'b0;
        check_outs(tag, gnt, we, wa, wd, busy, hit, fd, n == 0, mcnt);
        if (!rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (clr) mcnt = 0;
            else if (lw && (ee || n > 0) && mcnt < CNTMAX) mcnt++;
            if (n > 0 && !lw) void'(mq.pop_front());
            if (ee && gnt && !(n == 0 && !lw)) begin
                e.a = exa; e.d = exd;
                mq.push_back(e);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

    initial begin
        logic        r_rst, r_exr, r_lr, r_le, r_clr;
        logic [4:0]  r_exa, r_la, r_fa;
        logic [31:0] r_exd, r_ld, busy_m;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        // rst  exr exa exd        lr la ld       le fa clr | gnt we wa wd          busy     hit fd       idle cnt
        tbl.push_back(mk(0, 1, 5,  1,           1, 7,  2,       0, 0, 0,  0, 0, 0,  0,           0,       0, 0,       1, 0));
        tbl.push_back(mk(1, 1, 5,  32'hA5A5A5A5,0, 0,  0,       0, 0, 0,  1, 1, 5,  32'hA5A5A5A5,0,       0, 0,       1, 0));
        tbl.push_back(mk(1, 0, 0,  0,           0, 0,  0,       0, 0, 0,  1, 0, 0,  0,           0,       0, 0,       1, 0));
        tbl.push_back(mk(1, 1, 5,  'h22,        1, 7,  'h11,    0, 5, 0,  1, 1, 7,  'h11,        0,       0, 0,       1, 0));
        tbl.push_back(mk(1, 0, 0,  0,           0, 0,  0,       0, 5, 0,  1, 1, 5,  'h22,        'h20,    1, 'h22,    0, 1));
        tbl.push_back(mk(1, 0, 0,  0,           0, 0,  0,       0, 0, 1,  1, 0, 0,  0,           0,       0, 0,       1, 1));
        tbl.push_back(mk(1, 1, 3,  'h33,        1, 10, 'h100,   0, 3, 0,  1, 1, 10, 'h100,       0,       0, 0,       1, 0));
        tbl.push_back(mk(1, 1, 4,  'h44,        1, 11, 'h101,   0, 3, 0,  1, 1, 11, 'h101,       'h8,     1, 'h33,    0, 1));
        tbl.push_back(mk(1, 1, 6,  'h66,        1, 12, 'h102,   0, 4, 0,  0, 1, 12, 'h102,       'h18,    1, 'h44,    0, 2));
        tbl.push_back(mk(1, 1, 6,  'h66,        0, 0,  0,       0, 6, 0,  1, 1, 3,  'h33,        'h18,    0, 0,       0, 3));
        tbl.push_back(mk(1, 0, 0,  0,           0, 0,  0,       0, 6, 0,  1, 1, 4,  'h44,        'h50,    1, 'h66,    0, 3));
        tbl.push_back(mk(1, 0, 0,  0,           0, 0,  0,       0, 0, 0,  1, 1, 6,  'h66,        'h40,    0, 0,       0, 3));
        tbl.push_back(mk(1, 0, 0,  0,           0, 0,  0,       0, 0, 0,  1, 0, 0,  0,           0,       0, 0,       1, 3));
        tbl.push_back(mk(1, 1, 9,  1,           1, 20, 7,       0, 0, 0,  1, 1, 20, 7,           0,       0, 0,       1, 3));
        tbl.push_back(mk(1, 1, 9,  2,           1, 21, 8,       0, 9, 0,  1, 1, 21, 8,           'h200,   1, 1,       0, 4));
        tbl.push_back(mk(1, 0, 0,  0,           1, 22, 9,       0, 9, 0,  0, 1, 22, 9,           'h200,   1, 2,       0, 5));
        tbl.push_back(mk(1, 0, 0,  0,           1, 23, 10,      0, 0, 0,  0, 1, 23, 10,          'h200,   0, 0,       0, 6));
        tbl.push_back(mk(1, 0, 0,  0,           1, 24, 'hFF,    1, 9, 0,  1, 1, 9,  1,           'h200,   1, 2,       0, 7));
        tbl.push_back(mk(1, 0, 0,  0,           1, 24, 'hFF,    1, 9, 0,  1, 1, 9,  2,           'h200,   1, 2,       0, 7));
        tbl.push_back(mk(1, 1, 13, 'h13,        1, 25, 1,       0, 0, 0,  1, 1, 25, 1,           0,       0, 0,       1, 7));
        tbl.push_back(mk(1, 1, 14, 'h14,        1, 26, 2,       0, 14,0,  1, 1, 26, 2,           'h2000,  0, 0,       0, 8));
        tbl.push_back(mk(0, 1, 15, 'h15,        1, 27, 3,       0, 13,0,  0, 0, 0,  0,           'h6000,  1, 'h13,    0, 9));
        tbl.push_back(mk(1, 0, 0,  0,           0, 0,  0,       0, 13,0,  1, 0, 0,  0,           0,       0, 0,       1, 0));
        tbl.push_back(mk(1, 1, 0,  'hDEAD,      0, 0,  0,       0, 0, 0,  1, 0, 0,  0,           0,       0, 0,       1, 0));
        tbl.push_back(mk(1, 1, 2,  'h22,        1, 1,  'h11,    0, 0, 1,  1, 1, 1,  'h11,        0,       0, 0,       1, 0));
        tbl.push_back(mk(1, 0, 0,  0,           0, 0,  0,       0, 2, 0,  1, 1, 2,  'h22,        'h4,     1, 'h22,    0, 0));
        tbl.push_back(mk(1, 0, 0,  0,           0, 0,  0,       0, 0, 0,  1, 0, 0,  0,           0,       0, 0,       1, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].exr, tbl[i].exa, tbl[i].exd, tbl[i].lr, tbl[i].la,
                  tbl[i].ld, tbl[i].le, tbl[i].fa, tbl[i].clr);
            #2;
            check_outs($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].we, tbl[i].wa, tbl[i].wd,
                       tbl[i].busy, tbl[i].hit, tbl[i].fd, tbl[i].idle, tbl[i].cnt);
        end

        // Saturation: LSU streams while ID keeps asking for x1; queue fills, counter pins at max.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1, 1, 1, 32'(k), 1, 2, 32'h500 + 32'(k), 0, 1, 0);
            #2;
            if (k == 19) begin
                chk("sat gnt_full", 64'(ex_gnt), 64'd0);
                chk("sat fwd_youngest", {31'd0, fwd_hit, fwd_data}, {31'd0, 1'b1, 32'd1});
            end
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("sat cnt", 64'(coll_cnt), 64'(CNTMAX));
        chk("sat drain0", {27'd0, rf_we, rf_waddr, rf_wdata}, {27'd0, 1'b1, 5'd1, 32'd0});
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        chk("sat drain1", {27'd0, rf_we, rf_waddr, rf_wdata}, {27'd0, 1'b1, 5'd1, 32'd1});
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("sat clr", 64'(coll_cnt), 64'd0);
        chk("sat idle", 64'(idle), 64'd1);

        // Randomized traffic against the reference model, starting from reset.
        mq.delete();
        mcnt = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            r_rst = (c < 2) ? 1'b0 : ($urandom_range(0, 59) != 0);
            r_exr = ($urandom_range(0, 9) < 7);
            r_exa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r_exd = $urandom;
            r_lr  = ($urandom_range(0, 1) == 1);
            r_le  = ($urandom_range(0, 3) == 0);
            r_ld  = $urandom;
            busy_m = '0;
            foreach (mq[k]) busy_m[mq[k].a] = 1'b1;
            r_la = 5'($urandom_range(0, 31));
            for (int t = 0; t < 16 && busy_m[r_la] && r_la != 0; t++) r_la = 5'($urandom_range(0, 31));
            if (busy_m[r_la] && r_la != 0) r_la = 5'd0;
            r_fa  = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[mq.size() - 1].a : 5'($urandom_range(0, 31));
            r_clr = ($urandom_range(0, 19) == 0);
            drive(r_rst, r_exr, r_exa, r_exd, r_lr, r_la, r_ld, r_le, r_fa, r_clr);
            #2;
            model_step(r_rst, r_exr, r_exa, r_exd, r_lr, r_la, r_ld, r_le, r_fa, r_clr,
                       $sformatf("rnd%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
